// File: rtl/stack_frame_controller_pkg.sv
// Shared encodings and default pointer constants for the stack frame controller.
package stack_ctrl_pkg;

    localparam logic [15:0] STACK_TOP_DEF   = 16'hFF00;
    localparam logic [15:0] STACK_LIMIT_DEF = 16'hF000;

    typedef enum logic [2:0] {
        OP_PUSH    = 3'd0,
        OP_POP     = 3'd1,
        OP_ENTER   = 3'd2,
        OP_LEAVE   = 3'd3,
        OP_LOAD_SP = 3'd4,
        OP_ILL5    = 3'd5,
        OP_ILL6    = 3'd6,
        OP_ILL7    = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_WR,
        S_POP_RD,
        S_ENTER_WR,
        S_ENTER_ALLOC,
        S_LEAVE_SP,
        S_LEAVE_RD
    } state_e;

endpackage

// File: rtl/stack_frame_controller_if.sv
// Command and data-memory signals of the stack frame controller.
// slave = the controller, master = decoder/memory side.
interface stack_frame_controller_if
    import stack_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    op_e                   cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  done;
    logic                  fault;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] sp;
    logic [DATA_WIDTH-1:0] bp;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, mem_ack, mem_rdata,
        output cmd_ready, done, fault, resp_data,
        output mem_req, mem_we, mem_addr, mem_wdata, sp, bp
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, mem_ack, mem_rdata,
        input  cmd_ready, done, fault, resp_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, sp, bp
    );
endinterface

// File: rtl/stack_frame_controller_bounds_check.sv
// Combinational stack range check: flags a command that would leave
// [STACK_LIMIT, STACK_TOP]. Comparisons are done one bit wider to avoid wrap.
module stack_bounds_check
    import stack_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] STACK_TOP   = STACK_TOP_DEF,
    parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic [DATA_WIDTH-1:0] sp,
    input  logic [DATA_WIDTH-1:0] bp,
    input  op_e                   op,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  violation
);
    logic [DATA_WIDTH:0] enter_floor;

    // SP-1-data < LIMIT rewritten as SP < data+LIMIT+1 so nothing underflows
    assign enter_floor = {1'b0, data} + {1'b0, STACK_LIMIT} + 1'b1;

    always_comb begin
        violation = 1'b0;
        case (op)
            OP_PUSH:    violation = (sp == STACK_LIMIT);
            OP_POP:     violation = (sp == STACK_TOP);
            OP_ENTER:   violation = ({1'b0, sp} < enter_floor);
            OP_LEAVE:   violation = (bp == STACK_TOP);
            OP_LOAD_SP: violation = (data < STACK_LIMIT) || (data > STACK_TOP);
            default:    violation = 1'b0;
        endcase
    end
endmodule

// File: rtl/stack_frame_controller.sv
// Stack pointer / base pointer sequencer executing push, pop, enter, leave and
// SP load through a req/ack memory port. Range checks need STACK_BOUNDS_CHECK_EN.
module stack_frame_controller
    import stack_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] STACK_TOP   = STACK_TOP_DEF,
    parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input logic                     clock,
    input logic                     reset,
    stack_frame_controller_if.slave bus
);
    state_e                state;
    logic [DATA_WIDTH-1:0] sp_q, bp_q, data_q, addr_q, wdata_q, resp_q;
    logic                  req_q, we_q, done_q, fault_q;
    logic                  violation, illegal;

`ifdef STACK_BOUNDS_CHECK_EN
    stack_bounds_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .STACK_TOP  (STACK_TOP),
        .STACK_LIMIT(STACK_LIMIT)
    ) u_bounds (
        .sp       (sp_q),
        .bp       (bp_q),
        .op       (bus.cmd_op),
        .data     (bus.cmd_data),
        .violation(violation)
    );
`else
    logic unused_limit;
    assign unused_limit = ^STACK_LIMIT;
    assign violation    = 1'b0;
`endif

    assign illegal = bus.cmd_op inside {OP_ILL5, OP_ILL6, OP_ILL7};

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            sp_q    <= STACK_TOP;
            bp_q    <= STACK_TOP;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        data_q <= bus.cmd_data;
                        if (illegal || violation) begin
                            fault_q <= 1'b1;
                        end else begin
                            case (bus.cmd_op)
                                OP_PUSH: begin
                                    state   <= S_PUSH_WR;
                                    req_q   <= 1'b1;
                                    we_q    <= 1'b1;
                                    addr_q  <= sp_q - 1'b1;
                                    wdata_q <= bus.cmd_data;
                                end
                                OP_POP: begin
                                    state  <= S_POP_RD;
                                    req_q  <= 1'b1;
                                    we_q   <= 1'b0;
                                    addr_q <= sp_q;
                                end
                                OP_ENTER: begin
                                    state   <= S_ENTER_WR;
                                    req_q   <= 1'b1;
                                    we_q    <= 1'b1;
                                    addr_q  <= sp_q - 1'b1;
                                    wdata_q <= bp_q;
                                end
                                OP_LEAVE: state <= S_LEAVE_SP;
                                OP_LOAD_SP: begin
                                    sp_q   <= bus.cmd_data;
                                    done_q <= 1'b1;
                                end
                                default: fault_q <= 1'b1;
                            endcase
                        end
                    end
                end
                S_PUSH_WR: begin
                    if (req_q && bus.mem_ack) begin
                        req_q  <= 1'b0;
                        we_q   <= 1'b0;
                        sp_q   <= sp_q - 1'b1;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                S_POP_RD: begin
                    if (req_q && bus.mem_ack) begin
                        req_q  <= 1'b0;
                        resp_q <= bus.mem_rdata;
                        sp_q   <= sp_q + 1'b1;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                S_ENTER_WR: begin
                    // Old BP is saved; the saved slot becomes the new frame base
                    if (req_q && bus.mem_ack) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        sp_q  <= sp_q - 1'b1;
                        bp_q  <= sp_q - 1'b1;
                        state <= S_ENTER_ALLOC;
                    end
                end
                S_ENTER_ALLOC: begin
                    sp_q   <= sp_q - data_q;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                S_LEAVE_SP: begin
                    sp_q   <= bp_q;
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                    addr_q <= bp_q;
                    state  <= S_LEAVE_RD;
                end
                S_LEAVE_RD: begin
                    if (req_q && bus.mem_ack) begin
                        req_q  <= 1'b0;
                        bp_q   <= bus.mem_rdata;
                        sp_q   <= sp_q + 1'b1;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == S_IDLE) && !reset;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.resp_data = resp_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.sp        = sp_q;
    assign bus.bp        = bp_q;
endmodule

// File: tb/tb_stack_frame_controller.sv
// Directed bench for stack_frame_controller with a wait-state memory model;
// expectations follow STACK_BOUNDS_CHECK_EN when it is defined.
module tb_stack_frame_controller;
    import stack_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    stack_frame_controller_if #(.DATA_WIDTH(16)) bus ();

    stack_frame_controller dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Memory model: ack after wait_states idle request cycles
    logic [15:0] mem [0:65535];
    int          wait_states = 0;
    int          wcnt = 0;
    int          req_cycles = 0;
    logic [15:0] last_waddr = '0, last_wdata = '0, last_raddr = '0;

    assign bus.mem_ack   = bus.mem_req && (wcnt == wait_states);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clock) begin
        if (reset) mem[16'hFF00] <= 16'h5A5A;
        if (bus.mem_req) req_cycles <= req_cycles + 1;
        if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
                last_waddr        <= bus.mem_addr;
                last_wdata        <= bus.mem_wdata;
            end else begin
                last_raddr <= bus.mem_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("ready_in_reset", bus.cmd_ready, 0);
        reset = 1'b0;
        #1;
    endtask

    // Issues one command; lat = cycles from accept to done/fault (0 = timeout)
    task automatic run_cmd(input op_e op, input logic [15:0] data,
                           output int lat, output logic got_done, output logic got_fault);
        @(negedge clock);
        check("ready_at_issue", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        lat = 0; got_done = 1'b0; got_fault = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (bus.done || bus.fault) begin
                lat       = i;
                got_done  = bus.done;
                got_fault = bus.fault;
                break;
            end
        end
        if (lat != 0) check("ready_at_done", bus.cmd_ready, 1);
    endtask

    int   lat;
    logic d, f;
    int   req_snap;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_PUSH;
        bus.cmd_data  = '0;

        // Reset state
        do_reset();
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_sp", bus.sp, 16'hFF00);
        check("rst_bp", bus.bp, 16'hFF00);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_resp", bus.resp_data, 0);

        // PUSH, zero wait states
        run_cmd(OP_PUSH, 16'h1234, lat, d, f);
        check("push_lat", lat, 2);
        check("push_done", d, 1);
        check("push_waddr", last_waddr, 16'hFEFF);
        check("push_wdata", last_wdata, 16'h1234);
        check("push_sp", bus.sp, 16'hFEFF);

        // PUSH then POP with three wait states
        do_reset();
        run_cmd(OP_PUSH, 16'hAAAA, lat, d, f);
        check("push2_lat", lat, 2);
        wait_states = 3;
        run_cmd(OP_POP, 16'h0000, lat, d, f);
        check("pop_lat", lat, 5);
        check("pop_done", d, 1);
        check("pop_raddr", last_raddr, 16'hFEFF);
        check("pop_resp", bus.resp_data, 16'hAAAA);
        check("pop_sp", bus.sp, 16'hFF00);
        wait_states = 0;

        // ENTER 4 then LEAVE
        do_reset();
        run_cmd(OP_ENTER, 16'd4, lat, d, f);
        check("enter_lat", lat, 3);
        check("enter_done", d, 1);
        check("enter_waddr", last_waddr, 16'hFEFF);
        check("enter_wdata", last_wdata, 16'hFF00);
        check("enter_bp", bus.bp, 16'hFEFF);
        check("enter_sp", bus.sp, 16'hFEFB);
        run_cmd(OP_LEAVE, 16'h0000, lat, d, f);
        check("leave_lat", lat, 3);
        check("leave_done", d, 1);
        check("leave_raddr", last_raddr, 16'hFEFF);
        check("leave_sp", bus.sp, 16'hFF00);
        check("leave_bp", bus.bp, 16'hFF00);

        // Boundary sequence
        do_reset();
        req_snap = req_cycles;
`ifdef STACK_BOUNDS_CHECK_EN
        run_cmd(OP_POP, 16'h0000, lat, d, f);
        check("pop_empty_lat", lat, 1);
        check("pop_empty_fault", f, 1);
        check("pop_empty_sp", bus.sp, 16'hFF00);
        run_cmd(OP_LOAD_SP, 16'hEFFF, lat, d, f);
        check("ldsp_low_fault", f, 1);
        check("ldsp_low_sp", bus.sp, 16'hFF00);
        run_cmd(OP_LOAD_SP, 16'hF000, lat, d, f);
        check("ldsp_lim_lat", lat, 1);
        check("ldsp_lim_done", d, 1);
        check("ldsp_lim_sp", bus.sp, 16'hF000);
        run_cmd(OP_PUSH, 16'h7777, lat, d, f);
        check("push_full_lat", lat, 1);
        check("push_full_fault", f, 1);
        check("push_full_sp", bus.sp, 16'hF000);
        check("push_full_bp", bus.bp, 16'hFF00);
        check("no_mem_req", req_cycles - req_snap, 0);
`else
        run_cmd(OP_POP, 16'h0000, lat, d, f);
        check("pop_empty_lat", lat, 2);
        check("pop_empty_done", d, 1);
        check("pop_empty_raddr", last_raddr, 16'hFF00);
        check("pop_empty_resp", bus.resp_data, 16'h5A5A);
        check("pop_empty_sp", bus.sp, 16'hFF01);
        run_cmd(OP_LOAD_SP, 16'hEFFF, lat, d, f);
        check("ldsp_low_done", d, 1);
        check("ldsp_low_sp", bus.sp, 16'hEFFF);
        run_cmd(OP_LOAD_SP, 16'hF000, lat, d, f);
        check("ldsp_lim_lat", lat, 1);
        check("ldsp_lim_sp", bus.sp, 16'hF000);
        run_cmd(OP_PUSH, 16'h7777, lat, d, f);
        check("push_lim_lat", lat, 2);
        check("push_lim_waddr", last_waddr, 16'hEFFF);
        check("push_lim_wdata", last_wdata, 16'h7777);
        check("push_lim_sp", bus.sp, 16'hEFFF);
`endif

        // Illegal op faults in every build
        req_snap = req_cycles;
        run_cmd(OP_ILL5, 16'h0000, lat, d, f);
        check("illegal_lat", lat, 1);
        check("illegal_fault", f, 1);
        check("illegal_done", d, 0);
        check("illegal_no_req", req_cycles - req_snap, 0);

        // Reset while PUSH_WR waits for ack
        do_reset();
        wait_states = 20;
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_PUSH;
        bus.cmd_data  = 16'h5555;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clock);
        check("abort_req_before", bus.mem_req, 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_req_after", bus.mem_req, 0);
        check("abort_done", bus.done, 0);
        check("abort_sp", bus.sp, 16'hFF00);
        check("abort_bp", bus.bp, 16'hFF00);
        @(posedge clock);
        #1 reset = 1'b0;
        wait_states = 0;
        run_cmd(OP_LOAD_SP, 16'hF800, lat, d, f);
        check("post_abort_lat", lat, 1);
        check("post_abort_done", d, 1);
        check("post_abort_sp", bus.sp, 16'hF800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
